// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the CPU-to-RAM request sequencer.
package mem_ctrl_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned RAM_ADDR_W = 16;

    localparam logic       LANE_LO     = 1'b0;
    localparam logic       LANE_HI     = 1'b1;
    localparam logic [1:0] RAM_BE_FULL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR,
        RESP
    } state_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: CPU request/response and RAM port bundle of mem_ctrl.
// slave = the controller's view, master = the CPU/RAM environment's view.
interface mem_ctrl_if #(
    parameter int unsigned ADDR_W = 16
);
    import mem_ctrl_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic                  req_byte;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0]     ram_din;
    logic [1:0]            ram_be;
    logic                  ram_we;
    logic [DATA_W-1:0]     ram_dout;

    modport slave (
        input  req_valid, req_we, req_byte, req_addr, req_wdata, ram_dout,
        output req_ready, resp_valid, resp_rdata, resp_err,
               ram_addr, ram_din, ram_be, ram_we
    );

    modport master (
        output req_valid, req_we, req_byte, req_addr, req_wdata, ram_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               ram_addr, ram_din, ram_be, ram_we
    );

endinterface

// File: rtl/mem_lane.sv
// mem_lane: byte-lane extract (zero-extended) and byte-lane merge on a 16-bit word.
module mem_lane
    import mem_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic              lane,
    input  logic [7:0]        wr_byte,
    output logic [DATA_W-1:0] ext_data,
    output logic [DATA_W-1:0] merged
);

    // Select the addressed lane; the other lane of the merged word keeps the old byte.
    always_comb begin
        ext_data = '0;
        merged   = word;
        if (lane == LANE_LO) begin
            ext_data    = DATA_W'(word[7:0]);
            merged[7:0] = wr_byte;
        end else begin
            ext_data     = DATA_W'(word[15:8]);
            merged[15:8] = wr_byte;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences byte-addressed CPU loads/stores into word RAM cycles,
// covering the RAM's one-cycle read latency and byte stores as read-modify-write.
// Optional macro MEM_CTRL_ALIGN_CHECK_EN: misaligned word accesses return an
// error response without touching the RAM.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_ctrl_if.slave  bus
);

    logic [ADDR_W-1:0]     req_addr;
    state_t                state;
    logic                  we_q;
    logic                  byte_q;
    logic                  lane_q;
    logic [7:0]            wbyte_q;
    logic                  ready_q;
    logic                  resp_valid_q;
    logic [DATA_W-1:0]     resp_rdata_q;
    logic                  ram_we_q;
    logic [RAM_ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0]     ram_din_q;
    logic [DATA_W-1:0]     ext_data;
    logic [DATA_W-1:0]     merged;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    logic                  err_q;
`endif

    assign req_addr = ADDR_W'(bus.req_addr);

    // Lane extract for byte loads, lane merge for byte stores, on the word just read.
    mem_lane u_lane (
        .word     (bus.ram_dout),
        .lane     (lane_q),
        .wr_byte  (wbyte_q),
        .ext_data (ext_data),
        .merged   (merged)
    );

    // Sequencer; every output is set on the edge that enters the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            byte_q       <= 1'b0;
            lane_q       <= LANE_LO;
            wbyte_q      <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            ram_we_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q       <= bus.req_we;
                        byte_q     <= bus.req_byte;
                        lane_q     <= req_addr[0];
                        wbyte_q    <= bus.req_wdata[7:0];
                        ram_addr_q <= RAM_ADDR_W'(req_addr >> 1);
                        ready_q    <= 1'b0;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
                        err_q      <= 1'b0;
                        if (!bus.req_byte && req_addr[0]) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= '0;
                            err_q        <= 1'b1;
                        end else
`endif
                        if (bus.req_we && !bus.req_byte) begin
                            state     <= WR;
                            ram_we_q  <= 1'b1;
                            ram_din_q <= bus.req_wdata;
                        end else begin
                            state <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (we_q) begin
                        state     <= WR;
                        ram_we_q  <= 1'b1;
                        ram_din_q <= merged;
                    end else begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= byte_q ? ext_data : bus.ram_dout;
                    end
                end
                WR: begin
                    state        <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= '0;
                end
                RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_din    = ram_din_q;
    assign bus.ram_be     = RAM_BE_FULL;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    assign bus.resp_err   = err_q;
`else
    assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized and directed stimulus for mem_ctrl against a word-array reference model.
module tb_mem_ctrl;

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(16)) bus ();

    mem_ctrl #(.ADDR_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // RAM environment: registered read, full-word write.
    logic [15:0] ram     [256] = '{default: 16'h0000};
    logic [15:0] ref_mem [256] = '{default: 16'h0000};
    int          wr_cnt = 0;
    logic [15:0] last_wr_addr = 16'h0;
    logic [1:0]  last_wr_be = 2'b00;

    always @(posedge clk) begin
        bus.ram_dout <= ram[bus.ram_addr[7:0]];
        if (bus.ram_we) begin
            ram[bus.ram_addr[7:0]] <= bus.ram_din;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= bus.ram_addr;
            last_wr_be   <= bus.ram_be;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int cnt = 0;
        while (!bus.req_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_ready_wait"}, 32'(bus.req_ready), 32'd1);
    endtask

    // One request end to end; expectations come from the reference memory.
    task automatic do_req(input logic we, input logic bt, input logic [15:0] addr,
                          input logic [15:0] wdata, input string tag);
        logic [7:0]  w;
        logic [15:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
        int          sh;
        int          wr0;
        int          lat;
        w       = addr[8:1];
        sh      = addr[0] ? 8 : 0;
        exp_rd  = 16'h0;
        exp_err = 1'b0;
        exp_wr  = 0;
        if (ALIGN_CHK && !bt && addr[0]) begin
            exp_err = 1'b1;
            exp_lat = 1;
        end else if (we && !bt) begin
            ref_mem[w] = wdata;
            exp_lat    = 2;
            exp_wr     = 1;
        end else if (we) begin
            ref_mem[w] = (ref_mem[w] & ~(16'h00FF << sh)) | (16'(wdata[7:0]) << sh);
            exp_lat    = 4;
            exp_wr     = 1;
        end else begin
            exp_lat = 3;
            exp_rd  = bt ? ((ref_mem[w] >> sh) & 16'h00FF) : ref_mem[w];
        end

        wait_ready(tag);
        wr0           = wr_cnt;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_byte  = bt;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_wdata = 16'($urandom);
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, 32'(bus.resp_rdata), 32'(exp_rd));
        check({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
        check({tag, "_ready_busy"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        if (exp_wr != 0) begin
            check({tag, "_wr_addr"}, 32'(last_wr_addr), 32'(addr >> 1));
            check({tag, "_wr_be"}, 32'(last_wr_be), 32'h3);
        end
        check({tag, "_mem"}, 32'(ram[w]), 32'(ref_mem[w]));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_ready_idle"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_hold;
        int          wr0;

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 16'h0;
        bus.req_wdata = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_rdata", 32'(bus.resp_rdata), 32'd0);
        check("rst_err", 32'(bus.resp_err), 32'd0);
        check("rst_ram_we", 32'(bus.ram_we), 32'd0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_ram_din", 32'(bus.ram_din), 32'd0);
        check("rst_ram_be", 32'(bus.ram_be), 32'h3);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed scenarios.
        do_req(1'b1, 1'b0, 16'h0010, 16'hBEEF, "wst_10");
        do_req(1'b0, 1'b0, 16'h0010, 16'h0000, "wld_10");
        do_req(1'b1, 1'b0, 16'h0020, 16'h1234, "wst_20");
        do_req(1'b1, 1'b1, 16'h0021, 16'h55AB, "bst_21");
        check("merge_hi_word", 32'(ram[8'h10]), 32'hAB34);
        do_req(1'b1, 1'b1, 16'h0020, 16'h77CD, "bst_20");
        check("merge_lo_word", 32'(ram[8'h10]), 32'hABCD);
        do_req(1'b0, 1'b1, 16'h0021, 16'h0000, "bld_21");
        do_req(1'b0, 1'b1, 16'h0020, 16'h0000, "bld_20");
        do_req(1'b0, 1'b0, 16'h0011, 16'h0000, "misalign_ld");
        do_req(1'b1, 1'b0, 16'h0013, 16'h4321, "misalign_st");

        // Reset during RD_WAIT of a byte store aborts it without a write or response.
        wait_ready("rst_mid");
        wr0           = wr_cnt;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_byte  = 1'b1;
        bus.req_addr  = 16'h0020;
        bus.req_wdata = 16'h00EE;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mid_resp", 32'(bus.resp_valid), 32'd0);
        check("rst_mid_ram_we", 32'(bus.ram_we), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst_mid_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        check("rst_mid_no_write", 32'(wr_cnt - wr0), 32'd0);
        check("rst_mid_word", 32'(ram[8'h10]), 32'(ref_mem[8'h10]));

        // Held request: the second accept happens only in the IDLE cycle after the response.
        wait_ready("hold");
        exp_hold      = ref_mem[8'h10];
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 16'h0020;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("hold_ready", 32'(bus.req_ready), 32'((k == 4) || (k == 8)));
            check("hold_resp", 32'(bus.resp_valid), 32'((k == 3) || (k == 7)));
            if (k == 3 || k == 7)
                check("hold_rdata", 32'(bus.resp_rdata), 32'(exp_hold));
            if (k == 7)
                bus.req_valid = 1'b0;
        end

        // Preload the low region, then random traffic with frequent address reuse.
        for (int i = 0; i < 32; i++)
            do_req(1'b1, 1'b0, 16'(i * 2), 16'($urandom), "preload");
        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 63)) : 16'($urandom);
            do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
